// File: rtl/multicycle_controller.sv
// Control unit for a multicycle RISC-V style datapath. Strobes and selects that
// depend only on state and the latched fields are registered; handshake-qualified terms are not.
module multicycle_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        ResultSrc,
  output logic [1:0]  pc_src,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [4:0]  ALUcontrols,
  output logic [2:0]  ImmSrc,
  output logic [2:0]  MemRead,
  output logic [1:0]  MemWrite,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SLL  = 5'b00101;
  localparam logic [4:0] ALU_SLT  = 5'b00110;
  localparam logic [4:0] ALU_SLTU = 5'b00111;
  localparam logic [4:0] ALU_SRL  = 5'b01000;
  localparam logic [4:0] ALU_SRA  = 5'b01001;
  localparam logic [4:0] ALU_JALR = 5'b01010;
  localparam logic [4:0] ALU_BEQ  = 5'b01011;
  localparam logic [4:0] ALU_BNE  = 5'b01100;
  localparam logic [4:0] ALU_BLT  = 5'b01101;
  localparam logic [4:0] ALU_BGE  = 5'b01110;
  localparam logic [4:0] ALU_BLTU = 5'b01111;
  localparam logic [4:0] ALU_BGEU = 5'b10000;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       pc_write;
    logic       reg_write;
    logic       result_src;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [4:0] alu_ctrl;
    logic [2:0] imm_src;
    logic [2:0] mem_read;
    logic [1:0] mem_write;
    logic       illegal;
  } ctrl_t;

  function automatic logic known_op(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG: known_op = 1'b1;
      default:                           known_op = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] load_code(input logic [2:0] f3);
    case (f3)
      3'b000:  load_code = 3'b111;
      3'b001:  load_code = 3'b110;
      3'b010:  load_code = 3'b001;
      3'b100:  load_code = 3'b011;
      3'b101:  load_code = 3'b010;
      default: load_code = 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] store_code(input logic [2:0] f3);
    case (f3)
      3'b000:  store_code = 2'b11;
      3'b001:  store_code = 2'b10;
      3'b010:  store_code = 2'b01;
      default: store_code = 2'b00;
    endcase
  endfunction

  // A zero access code doubles as "undefined width" for loads and stores.
  function automatic logic exec_ok(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_BRANCH: exec_ok = (f3[2:1] != 2'b01);
      OP_LOAD:   exec_ok = (load_code(f3) != 3'b000);
      OP_STORE:  exec_ok = (store_code(f3) != 2'b00);
      default:   exec_ok = 1'b1;
    endcase
  endfunction

  function automatic logic [4:0] alu_op(input logic [2:0] f3, input logic alt,
                                        input logic is_reg);
    case (f3)
      3'b000:  alu_op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  function automatic logic [4:0] branch_op(input logic [2:0] f3);
    case (f3)
      3'b000:  branch_op = ALU_BEQ;
      3'b001:  branch_op = ALU_BNE;
      3'b100:  branch_op = ALU_BLT;
      3'b101:  branch_op = ALU_BGE;
      3'b110:  branch_op = ALU_BLTU;
      3'b111:  branch_op = ALU_BGEU;
      default: branch_op = ALU_ADD;
    endcase
  endfunction

  function automatic ctrl_t ctrl_for(input state_t s, input logic [6:0] op,
                                     input logic [2:0] f3, input logic alt);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: c.imem_req = 1'b1;
      EXEC: begin
        if (exec_ok(op, f3)) begin
          case (op)
            OP_REG: begin
              c.alu_ctrl = alu_op(f3, alt, 1'b1);
              c.imm_src  = 3'b111;
            end
            OP_IMM: begin
              c.alu_src_b = 2'b01;
              c.alu_ctrl  = alu_op(f3, alt, 1'b0);
              c.imm_src   = (f3 == 3'b101 && alt) ? 3'b101 : 3'b000;
            end
            OP_LUI: begin
              c.alu_src_b = 2'b01;
              c.imm_src   = 3'b001;
            end
            OP_AUIPC: begin
              c.alu_src_a = 1'b1;
              c.alu_src_b = 2'b01;
              c.imm_src   = 3'b001;
            end
            OP_JAL: begin
              c.alu_src_a = 1'b1;
              c.alu_src_b = 2'b11;
              c.imm_src   = 3'b100;
            end
            OP_JALR: begin
              c.alu_src_a = 1'b1;
              c.alu_src_b = 2'b11;
              c.alu_ctrl  = ALU_JALR;
            end
            OP_BRANCH: begin
              c.pc_write = 1'b1;
              c.imm_src  = 3'b011;
              c.alu_ctrl = branch_op(f3);
            end
            OP_LOAD: c.alu_src_b = 2'b01;
            OP_STORE: begin
              c.alu_src_b = 2'b01;
              c.imm_src   = 3'b010;
            end
            default: ;
          endcase
        end
      end
      MEM: begin
        c.dmem_req = 1'b1;
        if (op == OP_LOAD) c.mem_read = load_code(f3);
        else               c.mem_write = store_code(f3);
      end
      WB: begin
        c.reg_write  = 1'b1;
        c.pc_write   = 1'b1;
        c.result_src = (op == OP_LOAD);
        c.pc_src     = (op == OP_JAL) ? 2'b01 : (op == OP_JALR) ? 2'b10 : 2'b00;
      end
      TRAP: c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  state_t      state_reg, state_next;
  ctrl_t       ctrl_reg, ctrl_next;
  logic [6:0]  op_reg, op_next;
  logic [2:0]  f3_reg, f3_next;
  logic [6:0]  f7_reg, f7_next;
  logic [31:0] instret_reg;
  logic        retire;
  logic        store_done;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:  if (ctrl_reg.imem_req && imem_ready) state_next = DECODE;
      DECODE: state_next = known_op(opcode) ? EXEC : TRAP;
      EXEC: begin
        if (!exec_ok(op_reg, f3_reg))                      state_next = TRAP;
        else if (op_reg == OP_BRANCH)                      state_next = FETCH;
        else if (op_reg == OP_LOAD || op_reg == OP_STORE)  state_next = MEM;
        else                                               state_next = WB;
      end
      MEM:    if (dmem_ready) state_next = (op_reg == OP_LOAD) ? WB : FETCH;
      WB:     state_next = FETCH;
      TRAP:   state_next = TRAP;
      default: state_next = TRAP;
    endcase
  end

  // Fields entering EXEC come straight from the instruction register.
  always_comb begin
    op_next   = (state_reg == DECODE) ? opcode : op_reg;
    f3_next   = (state_reg == DECODE) ? func3  : f3_reg;
    f7_next   = (state_reg == DECODE) ? func7  : f7_reg;
    ctrl_next = ctrl_for(state_next, op_next, f3_next, f7_next[5]);
    retire    = (state_next == FETCH) &&
                (state_reg == EXEC || state_reg == MEM || state_reg == WB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= FETCH;
      ctrl_reg    <= '0;
      op_reg      <= '0;
      f3_reg      <= '0;
      f7_reg      <= '0;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= ctrl_next;
      op_reg    <= op_next;
      f3_reg    <= f3_next;
      f7_reg    <= f7_next;
      if (retire) instret_reg <= instret_reg + 32'd1;
    end
  end

  assign store_done  = (state_reg == MEM) && (op_reg == OP_STORE) && dmem_ready;

  assign imem_req    = ctrl_reg.imem_req;
  assign dmem_req    = ctrl_reg.dmem_req;
  assign IRWrite     = (state_reg == FETCH) && ctrl_reg.imem_req && imem_ready;
  assign PCWrite     = ctrl_reg.pc_write || store_done;
  assign RegWrite    = ctrl_reg.reg_write;
  assign ResultSrc   = ctrl_reg.result_src;
  // Only a branch raises pc_write in EXEC, where the target hinges on the compare.
  assign pc_src      = (state_reg == EXEC && ctrl_reg.pc_write) ? {1'b0, branch_taken}
                                                                : ctrl_reg.pc_src;
  assign ALUSrcA     = ctrl_reg.alu_src_a;
  assign ALUSrcB     = ctrl_reg.alu_src_b;
  assign ALUcontrols = ctrl_reg.alu_ctrl;
  assign ImmSrc      = ctrl_reg.imm_src;
  assign MemRead     = ctrl_reg.mem_read;
  assign MemWrite    = ctrl_reg.mem_write;
  assign state       = state_reg;
  assign illegal     = ctrl_reg.illegal;
  assign instret     = instret_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scenarios for multicycle_controller; one task per scenario, inline checks.
`timescale 1ns/1ps
module tb_multicycle_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  func3 = '0;
  logic [6:0]  func7 = '0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        imem_req, dmem_req, IRWrite, PCWrite, RegWrite, ResultSrc;
  logic [1:0]  pc_src;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [4:0]  ALUcontrols;
  logic [2:0]  ImmSrc;
  logic [2:0]  MemRead;
  logic [1:0]  MemWrite;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_instret = '0;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7(func7),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .pc_src(pc_src), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUcontrols(ALUcontrols), .ImmSrc(ImmSrc), .MemRead(MemRead),
    .MemWrite(MemWrite), .state(state), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req got %b want 0", imem_req); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got %h want 0", instret); end
    checks++; if ({illegal, dmem_req, PCWrite, RegWrite, MemRead, MemWrite} !== 9'd0) begin
      errors++; $display("FAIL reset_strobes got %b want 0", {illegal, dmem_req, PCWrite, RegWrite, MemRead, MemWrite}); end
    rst_n = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || state !== 3'd0) begin
      errors++; $display("FAIL reset_first_fetch imem_req=%b state=%0d want 1/0", imem_req, state); end
    $display("reset: state=%0d imem_req=%b instret=%h", state, imem_req, instret);
  endtask

  task automatic test_add();
    int cyc;
    cyc = 0;
    opcode = 7'b0110011; func3 = 3'b000; func7 = 7'b0000000;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    #1;
    checks++; if (IRWrite !== 1'b1) begin errors++; $display("FAIL add_irwrite got %b want 1", IRWrite); end
    step(); cyc++;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL add_decode state got %0d want 1", state); end
    step(); cyc++;
    checks++; if (state !== 3'd2 || ALUcontrols !== 5'b00000 || ImmSrc !== 3'b111 || ALUSrcB !== 2'b00) begin
      errors++; $display("FAIL add_exec state=%0d alu=%b imm=%b srcb=%b want 2/00000/111/00", state, ALUcontrols, ImmSrc, ALUSrcB); end
    step(); cyc++;
    checks++; if (state !== 3'd4 || RegWrite !== 1'b1 || PCWrite !== 1'b1 || ResultSrc !== 1'b0 || pc_src !== 2'b00) begin
      errors++; $display("FAIL add_wb state=%0d rw=%b pcw=%b rs=%b pcsrc=%b want 4/1/1/0/00", state, RegWrite, PCWrite, ResultSrc, pc_src); end
    step(); cyc++;
    imem_ready = 1'b0;
    exp_instret = exp_instret + 32'd1;
    checks++; if (state !== 3'd0 || instret !== exp_instret || cyc != 4) begin
      errors++; $display("FAIL add_retire state=%0d instret=%h cycles=%0d want 0/%h/4", state, instret, cyc, exp_instret); end
    $display("add: cycles=%0d instret=%h", cyc, instret);
  endtask

  task automatic test_lw_wait();
    int cyc;
    cyc = 0;
    opcode = 7'b0000011; func3 = 3'b010; func7 = 7'b0000000;
    imem_ready = 1'b1; dmem_ready = 1'b0;
    step(); cyc++;
    imem_ready = 1'b0;
    step(); cyc++;
    checks++; if (state !== 3'd2 || ALUcontrols !== 5'b00000 || ALUSrcB !== 2'b01 || ImmSrc !== 3'b000) begin
      errors++; $display("FAIL lw_exec state=%0d alu=%b srcb=%b imm=%b want 2/00000/01/000", state, ALUcontrols, ALUSrcB, ImmSrc); end
    for (int k = 0; k < 3; k++) begin
      step(); cyc++;
      checks++; if (state !== 3'd3 || dmem_req !== 1'b1 || MemRead !== 3'b001 || MemWrite !== 2'b00) begin
        errors++; $display("FAIL lw_mem%0d state=%0d dreq=%b rd=%b wr=%b want 3/1/001/00", k, state, dmem_req, MemRead, MemWrite); end
      if (k == 2) dmem_ready = 1'b1;
    end
    step(); cyc++;
    checks++; if (state !== 3'd4 || ResultSrc !== 1'b1 || RegWrite !== 1'b1 || dmem_req !== 1'b0 || MemRead !== 3'b000) begin
      errors++; $display("FAIL lw_wb state=%0d rs=%b rw=%b dreq=%b rd=%b want 4/1/1/0/000", state, ResultSrc, RegWrite, dmem_req, MemRead); end
    step(); cyc++;
    exp_instret = exp_instret + 32'd1;
    checks++; if (state !== 3'd0 || instret !== exp_instret || cyc != 7) begin
      errors++; $display("FAIL lw_retire state=%0d instret=%h cycles=%0d want 0/%h/7", state, instret, cyc, exp_instret); end
    $display("lw: cycles=%0d instret=%h", cyc, instret);
  endtask

  task automatic test_bne(input logic taken);
    int cyc;
    cyc = 0;
    opcode = 7'b1100011; func3 = 3'b001; func7 = 7'b0000000;
    branch_taken = taken; imem_ready = 1'b1;
    step(); cyc++;
    imem_ready = 1'b0;
    step(); cyc++;
    checks++; if (state !== 3'd2 || ALUcontrols !== 5'b01100 || ImmSrc !== 3'b011) begin
      errors++; $display("FAIL bne_exec state=%0d alu=%b imm=%b want 2/01100/011", state, ALUcontrols, ImmSrc); end
    checks++; if (PCWrite !== 1'b1 || pc_src !== {1'b0, taken} || RegWrite !== 1'b0) begin
      errors++; $display("FAIL bne_pc taken=%b pcw=%b pcsrc=%b rw=%b want 1/0%b/0", taken, PCWrite, pc_src, RegWrite, taken); end
    step(); cyc++;
    exp_instret = exp_instret + 32'd1;
    checks++; if (state !== 3'd0 || instret !== exp_instret || cyc != 3 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL bne_retire state=%0d instret=%h cycles=%0d want 0/%h/3", state, instret, cyc, exp_instret); end
    $display("bne taken=%b: cycles=%0d instret=%h", taken, cyc, instret);
  endtask

  task automatic test_jal();
    opcode = 7'b1101111; func3 = 3'b000; func7 = 7'b0000000;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    checks++; if (ALUSrcA !== 1'b1 || ALUSrcB !== 2'b11 || ImmSrc !== 3'b100 || ALUcontrols !== 5'b00000) begin
      errors++; $display("FAIL jal_exec srca=%b srcb=%b imm=%b alu=%b want 1/11/100/00000", ALUSrcA, ALUSrcB, ImmSrc, ALUcontrols); end
    step();
    checks++; if (state !== 3'd4 || pc_src !== 2'b01 || RegWrite !== 1'b1 || ALUSrcA !== 1'b0) begin
      errors++; $display("FAIL jal_wb state=%0d pcsrc=%b rw=%b srca=%b want 4/01/1/0", state, pc_src, RegWrite, ALUSrcA); end
    step();
    exp_instret = exp_instret + 32'd1;
    checks++; if (state !== 3'd0 || instret !== exp_instret) begin
      errors++; $display("FAIL jal_retire state=%0d instret=%h want 0/%h", state, instret, exp_instret); end
    $display("jal: instret=%h", instret);
  endtask

  task automatic test_sw();
    int cyc;
    cyc = 0;
    opcode = 7'b0100011; func3 = 3'b010; func7 = 7'b0000000;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    step(); cyc++;
    imem_ready = 1'b0;
    step(); cyc++;
    checks++; if (ImmSrc !== 3'b010 || ALUSrcB !== 2'b01 || PCWrite !== 1'b0) begin
      errors++; $display("FAIL sw_exec imm=%b srcb=%b pcw=%b want 010/01/0", ImmSrc, ALUSrcB, PCWrite); end
    step(); cyc++;
    checks++; if (state !== 3'd3 || MemWrite !== 2'b01 || MemRead !== 3'b000 || dmem_req !== 1'b1 || PCWrite !== 1'b1 || pc_src !== 2'b00) begin
      errors++; $display("FAIL sw_mem state=%0d wr=%b rd=%b dreq=%b pcw=%b pcsrc=%b want 3/01/000/1/1/00", state, MemWrite, MemRead, dmem_req, PCWrite, pc_src); end
    step(); cyc++;
    exp_instret = exp_instret + 32'd1;
    checks++; if (state !== 3'd0 || instret !== exp_instret || cyc != 4 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL sw_retire state=%0d instret=%h cycles=%0d want 0/%h/4", state, instret, cyc, exp_instret); end
    $display("sw: cycles=%0d instret=%h", cyc, instret);
  endtask

  task automatic test_sb_reset();
    opcode = 7'b0100011; func3 = 3'b000; func7 = 7'b0000000;
    imem_ready = 1'b1; dmem_ready = 1'b0;
    step();
    imem_ready = 1'b0;
    step();
    step();
    checks++; if (state !== 3'd3 || dmem_req !== 1'b1 || MemWrite !== 2'b11) begin
      errors++; $display("FAIL sb_mem state=%0d dreq=%b wr=%b want 3/1/11", state, dmem_req, MemWrite); end
    #2;
    rst_n = 1'b0;
    #1;
    exp_instret = '0;
    checks++; if (dmem_req !== 1'b0 || MemWrite !== 2'b00 || state !== 3'd0 || instret !== 32'd0) begin
      errors++; $display("FAIL sb_async_reset dreq=%b wr=%b state=%0d instret=%h want 0/00/0/0", dmem_req, MemWrite, state, instret); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || state !== 3'd0) begin
      errors++; $display("FAIL sb_restart imem_req=%b state=%0d want 1/0", imem_req, state); end
    $display("sb reset mid-MEM: state=%0d instret=%h", state, instret);
  endtask

  task automatic test_wrap();
    force dut.instret_reg = 32'hFFFF_FFFF;
    #1;
    release dut.instret_reg;
    exp_instret = 32'hFFFF_FFFF;
    test_add();
    checks++; if (instret !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_instret got %h want 00000000", instret); end
    $display("wrap: instret=%h", instret);
  endtask

  task automatic test_trap();
    opcode = 7'b1111111; func3 = 3'b000; func7 = 7'b0000000;
    imem_ready = 1'b1;
    step();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL trap_decode state got %0d want 1", state); end
    step();
    checks++; if (state !== 3'd5 || illegal !== 1'b1) begin
      errors++; $display("FAIL trap_enter state=%0d illegal=%b want 5/1", state, illegal); end
    dmem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++; if (state !== 3'd5 || illegal !== 1'b1 || instret !== exp_instret ||
                    {imem_req, dmem_req, IRWrite, PCWrite, RegWrite} !== 5'd0) begin
        errors++; $display("FAIL trap_hold%0d state=%0d illegal=%b instret=%h strobes=%b want 5/1/%h/00000", k, state, illegal, instret,
                           {imem_req, dmem_req, IRWrite, PCWrite, RegWrite}, exp_instret); end
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    $display("trap: state=%0d illegal=%b instret=%h", state, illegal, instret);
  endtask

  task automatic test_bad_branch();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_instret = '0;
    step();
    checks++; if (illegal !== 1'b0 || state !== 3'd0) begin
      errors++; $display("FAIL badbr_reset illegal=%b state=%0d want 0/0", illegal, state); end
    opcode = 7'b1100011; func3 = 3'b010; func7 = 7'b0000000;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    checks++; if (state !== 3'd2 || PCWrite !== 1'b0) begin
      errors++; $display("FAIL badbr_exec state=%0d pcw=%b want 2/0", state, PCWrite); end
    step();
    checks++; if (state !== 3'd5 || illegal !== 1'b1 || instret !== 32'd0) begin
      errors++; $display("FAIL badbr_trap state=%0d illegal=%b instret=%h want 5/1/0", state, illegal, instret); end
    $display("bad branch func3: state=%0d illegal=%b", state, illegal);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_bne(1'b1);
    test_bne(1'b0);
    test_jal();
    test_sw();
    test_sb_reset();
    test_wrap();
    test_trap();
    test_bad_branch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
